viterbi_path_streamer: RTL and testbench

Downstream stage of the Viterbi decoder core. Captures the decoded state path vector and its length when the decoder signals completion, then serializes the path one state per beat over a valid/ready stream in time order (index 0 first). It also counts state switches along the path and flags overruns and illegal state codes, so the consumer sees a clean packetized stream and the decoder can be restarted as soon as capture completes.

---
 rtl/viterbi_path_streamer.sv | 129 ++++++++++++
 tb/tb_viterbi_path_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_path_streamer.sv
// Captures a decoded Viterbi state path on the rising edge of done_in and streams it
// one state per beat over valid/ready, with switch counting and sticky error flags.
module viterbi_path_streamer #(
    parameter int N  = 16,
    parameter int I  = 3,
    parameter int SW = (I > 1) ? $clog2(I) : 1,
    parameter int LW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*SW-1:0]   path_in,
    input  logic [LW-1:0]     length_in,
    input  logic              done_in,
    input  logic              clr,
    output logic              busy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SW-1:0]     m_state,
    output logic [LW-1:0]     m_index,
    output logic              m_last,
    output logic [LW-1:0]     switch_count,
    output logic              stats_valid,
    output logic              overrun,
    output logic              err_state,
    output logic              err_len
);

    // State  | meaning
    // IDLE   | waiting for a done_in rising edge with a non-zero length
    // STREAM | presenting buffered beats, advancing on each handshake
    typedef enum logic {IDLE, STREAM} state_t;

    // SW+1 bits so the bound is representable even when I is a power of two
    localparam logic [SW:0] I_CODE = (SW+1)'(I);

    state_t            state_q, state_d;
    logic              done_q;
    logic [N*SW-1:0]   path_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     acc_q;
    logic [SW-1:0]     prev_q;
    logic              cap;
    logic              accept;
    logic              is_switch;
    logic              bad_code;
    logic [LW-1:0]     nxt_idx;

    assign cap       = done_in & ~done_q;
    assign busy      = (state_q == STREAM);
    assign m_valid   = (state_q == STREAM);
    assign accept    = m_valid & m_ready;
    assign is_switch = (m_index != '0) && (m_state != prev_q);
    assign bad_code  = ({1'b0, m_state} >= I_CODE);
    assign nxt_idx   = m_index + {{(LW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap && length_in != '0) state_d = STREAM;
            STREAM:  if (accept && m_last)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs are registered: loaded on capture and on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q       <= 1'b0;
            path_q       <= '0;
            len_q        <= '0;
            acc_q        <= '0;
            prev_q       <= '0;
            m_state      <= '0;
            m_index      <= '0;
            m_last       <= 1'b0;
            switch_count <= '0;
            stats_valid  <= 1'b0;
        end else begin
            done_q      <= done_in;
            stats_valid <= 1'b0;
            if (state_q == IDLE) begin
                if (cap && length_in != '0) begin
                    path_q  <= path_in;
                    len_q   <= length_in;
                    acc_q   <= '0;
                    m_index <= '0;
                    m_state <= path_in[SW-1:0];
                    m_last  <= (length_in == {{(LW-1){1'b0}}, 1'b1});
                end
            end else if (accept) begin
                prev_q <= m_state;
                if (is_switch) acc_q <= acc_q + {{(LW-1){1'b0}}, 1'b1};
                if (m_last) begin
                    switch_count <= acc_q + {{(LW-1){1'b0}}, is_switch};
                    stats_valid  <= 1'b1;
                    m_index      <= '0;
                    m_state      <= '0;
                    m_last       <= 1'b0;
                end else begin
                    m_index <= nxt_idx;
                    m_state <= path_q[nxt_idx*SW +: SW];
                    m_last  <= (nxt_idx == len_q - {{(LW-1){1'b0}}, 1'b1});
                end
            end
        end
    end

    // Sticky flags: a set condition in the same cycle as clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            err_state <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            if (cap && state_q == STREAM)                   overrun <= 1'b1;
            else if (clr)                                   overrun <= 1'b0;
            if (accept && bad_code)                         err_state <= 1'b1;
            else if (clr)                                   err_state <= 1'b0;
            if (cap && state_q == IDLE && length_in == '0)  err_len <= 1'b1;
            else if (clr)                                   err_len <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_path_streamer.sv
// Directed bench for viterbi_path_streamer: a packet-level model is checked against
// the DUT every cycle, plus literal expectations for each scenario.
module tb_viterbi_path_streamer;
    localparam int N  = 16;
    localparam int I  = 3;
    localparam int SW = 2;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*SW-1:0]   path_in = '0;
    logic [LW-1:0]     length_in = '0;
    logic              done_in = 1'b0;
    logic              clr = 1'b0;
    logic              m_ready = 1'b0;
    logic              busy, m_valid, m_last, stats_valid, overrun, err_state, err_len;
    logic [SW-1:0]     m_state;
    logic [LW-1:0]     m_index, switch_count;

    viterbi_path_streamer #(.N(N), .I(I)) dut (
        .clk(clk), .rst_n(rst_n), .path_in(path_in), .length_in(length_in),
        .done_in(done_in), .clr(clr), .busy(busy), .m_valid(m_valid),
        .m_ready(m_ready), .m_state(m_state), .m_index(m_index), .m_last(m_last),
        .switch_count(switch_count), .stats_valid(stats_valid), .overrun(overrun),
        .err_state(err_state), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int beats  = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level model: a captured path, a position in it, and sticky flags.
    int mp[N];
    int mL = 0, mpos = 0, mswc = 0;
    bit mbusy = 0, mstats = 0, mov = 0, mes = 0, mel = 0, mdq = 0;

    function automatic int count_switches();
        int c = 0;
        for (int k = 1; k < mL; k++) if (mp[k] != mp[k-1]) c++;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy = 0; mstats = 0; mov = 0; mes = 0; mel = 0; mdq = 0;
            mpos = 0; mswc = 0; mL = 0;
        end else begin
            bit rise, s_ov, s_es, s_el, fin;
            rise = done_in && !mdq;
            s_ov = 0; s_es = 0; s_el = 0; fin = 0;
            if (mbusy) begin
                if (rise) s_ov = 1;
                if (m_ready) begin
                    if (mp[mpos] >= I) s_es = 1;
                    if (mpos == mL - 1) begin
                        fin = 1;
                        mbusy = 0;
                        mswc = count_switches();
                    end else begin
                        mpos++;
                    end
                end
            end else if (rise) begin
                if (length_in == 0) s_el = 1;
                else begin
                    for (int k = 0; k < N; k++) mp[k] = int'(path_in[k*SW +: SW]);
                    mL = int'(length_in);
                    mpos = 0;
                    mbusy = 1;
                end
            end
            mstats = fin;
            mov = s_ov ? 1'b1 : (clr ? 1'b0 : mov);
            mes = s_es ? 1'b1 : (clr ? 1'b0 : mes);
            mel = s_el ? 1'b1 : (clr ? 1'b0 : mel);
            mdq = done_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",         int'(busy),         int'(mbusy));
            chk("m_valid",      int'(m_valid),      int'(mbusy));
            chk("m_state",      int'(m_state),      mbusy ? mp[mpos] : 0);
            chk("m_index",      int'(m_index),      mbusy ? mpos : 0);
            chk("m_last",       int'(m_last),       int'(mbusy && mpos == mL - 1));
            chk("switch_count", int'(switch_count), mswc);
            chk("stats_valid",  int'(stats_valid),  int'(mstats));
            chk("overrun",      int'(overrun),      int'(mov));
            chk("err_state",    int'(err_state),    int'(mes));
            chk("err_len",      int'(err_len),      int'(mel));
            if (m_valid && m_ready) beats++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int vals[$]);
        path_in = '0;
        for (int k = 0; k < vals.size(); k++) path_in[k*SW +: SW] = vals[k][SW-1:0];
        length_in = LW'(vals.size());
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating. redo: cycle to re-raise done_in.
    task automatic run_packet(input int mode, input int redo);
        int cyc = 0;
        bit got = 0;
        beats = 0;
        done_in = 1'b1;
        while (!got && cyc < 200) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            tick();
            cyc++;
            if (cyc == 1)        done_in = 1'b0;
            if (cyc == redo)     done_in = 1'b1;
            if (cyc == redo + 1) done_in = 1'b0;
            if (stats_valid) got = 1;
        end
        done_in = 1'b0;
        chk("packet_complete", int'(got), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        #2 chk_en = 1;
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_switch_count", int'(switch_count), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        load('{0, 1, 1, 2, 0});
        run_packet(0, -5);
        chk("p1_beats", beats, 5);
        chk("p1_switches", int'(switch_count), 3);
        tick();
        chk("p1_stats_pulse_once", int'(stats_valid), 0);

        load('{0, 1, 1, 2, 0});
        run_packet(1, -5);
        chk("stall_beats", beats, 5);
        chk("stall_switches", int'(switch_count), 3);
        tick();

        load('{2});
        run_packet(0, -5);
        chk("single_beats", beats, 1);
        chk("single_switches", int'(switch_count), 0);
        tick();

        load('{0, 1, 2, 2, 1, 0, 0, 1});
        run_packet(0, 2);
        chk("ovr_beats", beats, 8);
        chk("ovr_switches", int'(switch_count), 5);
        chk("ovr_flag", int'(overrun), 1);
        repeat (5) tick();
        chk("ovr_no_second_packet", int'(m_valid), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        path_in = '0;
        length_in = '0;
        done_in = 1'b1;
        tick();
        tick();
        done_in = 1'b0;
        chk("len0_err_len", int'(err_len), 1);
        chk("len0_no_valid", int'(m_valid), 0);
        tick();

        load('{0, 3, 1});
        run_packet(0, -5);
        chk("bad_beats", beats, 3);
        chk("bad_err_state", int'(err_state), 1);
        chk("bad_switches", int'(switch_count), 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err_state", int'(err_state), 0);
        chk("clr_err_len", int'(err_len), 0);

        load('{1, 1, 2, 0, 0, 2});
        m_ready = 1'b1;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (3) tick();
        chk("pre_reset_index", int'(m_index), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_m_index", int'(m_index), 0);
        chk("rst_m_state", int'(m_state), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_packet(0, -5);
        chk("post_reset_beats", beats, 6);
        chk("post_reset_switches", int'(switch_count), 3);
        tick();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
